module_captura_numeros: RTL and testbench

- Operand-entry front end for the adder datapath. Converts decimal digits keyed on the 4 DIP switches, each confirmed by a push button, into two 12-bit binary operands.
- Outputs feed the adder's `num1`/`num2` inputs.
- Synchronises and debounces both buttons, validates the BCD digits, and sequences entry of 3 digits per operand with a small FSM.
- Raises a ready flag once both operands are complete.

---
 rtl/module_captura_numeros.sv | 174 +++++++++++++++++
 tb/tb_module_captura_numeros.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/module_captura_numeros.sv
// Operand-entry front end: debounced buttons plus DIP-switch BCD digits are
// accumulated into two 12-bit binary operands for the adder datapath.

module captura_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] synced
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end
endmodule

// A level change is accepted only after DEBOUNCE_CYCLES consecutive cycles of
// disagreement; any agreeing cycle restarts the count.
module captura_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic level_sync,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          level_db;
    logic          level_db_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            level_db   <= 1'b0;
            level_db_q <= 1'b0;
            press      <= 1'b0;
        end else begin
            level_db_q <= level_db;
            press      <= level_db & ~level_db_q;
            if (level_sync == level_db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_db <= ~level_db;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module module_captura_numeros #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int DIGITS          = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw_digit,
    input  logic        btn_ingresar,
    input  logic        btn_borrar,
    output logic [11:0] first_num,
    output logic [11:0] second_num,
    output logic        numeros_listos,
    output logic        listo_pulso,
    output logic        error_digito,
    output logic [1:0]  estado,
    output logic [1:0]  digitos
);
    localparam int NUM_BTNS = 2;
    localparam logic [1:0] LAST_DIGIT = 2'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_NUM1  = 2'd0,
        S_NUM2  = 2'd1,
        S_LISTO = 2'd2
    } state_t;

    logic [3:0]          digit_sync;
    logic [NUM_BTNS-1:0] btn_sync;
    logic [NUM_BTNS-1:0] btn_press;
    logic                press_ingresar;
    logic                press_borrar;

    state_t     state;
    logic [1:0] cnt;

    captura_sync #(.W(4 + NUM_BTNS)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .raw    ({sw_digit, btn_borrar, btn_ingresar}),
        .synced ({digit_sync, btn_sync})
    );

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_db
        captura_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk        (clk),
            .rst        (rst),
            .level_sync (btn_sync[b]),
            .press      (btn_press[b])
        );
    end

    assign press_ingresar = btn_press[0];
    assign press_borrar   = btn_press[1];

    // x*10 as (x<<3)+(x<<1); operands never exceed 999 so 12 bits suffice.
    function automatic logic [11:0] append_digit(input logic [11:0] x, input logic [3:0] d);
        return (x << 3) + (x << 1) + {8'd0, d};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_NUM1;
            cnt            <= '0;
            first_num      <= '0;
            second_num     <= '0;
            numeros_listos <= 1'b0;
            listo_pulso    <= 1'b0;
            error_digito   <= 1'b0;
        end else begin
            listo_pulso  <= 1'b0;
            error_digito <= 1'b0;
            // Clear outranks a simultaneous enter: the digit is dropped silently.
            if (press_borrar) begin
                state          <= S_NUM1;
                cnt            <= '0;
                first_num      <= '0;
                second_num     <= '0;
                numeros_listos <= 1'b0;
            end else if (press_ingresar && state != S_LISTO) begin
                if (digit_sync > 4'd9) begin
                    error_digito <= 1'b1;
                end else begin
                    case (state)
                        S_NUM1: begin
                            first_num <= append_digit(first_num, digit_sync);
                            if (cnt == LAST_DIGIT) begin
                                state <= S_NUM2;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        S_NUM2: begin
                            second_num <= append_digit(second_num, digit_sync);
                            if (cnt == LAST_DIGIT) begin
                                state          <= S_LISTO;
                                cnt            <= '0;
                                listo_pulso    <= 1'b1;
                                numeros_listos <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign estado  = state;
    assign digitos = cnt;
endmodule

// File: tb/tb_module_captura_numeros.sv
// Self-checking bench: a table of keyed operations with expected results fed
// through a scoreboard queue, plus hand-written bounce/latency sequences.

module tb_module_captura_numeros;
    localparam int D   = 4;
    localparam int LAT = D + 4;

    localparam logic [1:0] OP_ENTER = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_BOTH  = 2'd2;
    localparam logic [1:0] OP_RESET = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw_digit;
    logic        btn_ingresar;
    logic        btn_borrar;
    logic [11:0] first_num;
    logic [11:0] second_num;
    logic        numeros_listos;
    logic        listo_pulso;
    logic        error_digito;
    logic [1:0]  estado;
    logic [1:0]  digitos;

    always #5 clk = ~clk;

    module_captura_numeros #(.DEBOUNCE_CYCLES(D), .DIGITS(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_digit       (sw_digit),
        .btn_ingresar   (btn_ingresar),
        .btn_borrar     (btn_borrar),
        .first_num      (first_num),
        .second_num     (second_num),
        .numeros_listos (numeros_listos),
        .listo_pulso    (listo_pulso),
        .error_digito   (error_digito),
        .estado         (estado),
        .digitos        (digitos)
    );

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  sw;
        logic [11:0] f;
        logic [11:0] s;
        logic        lst;
        logic [1:0]  est;
        logic [1:0]  dig;
        int          n_listo;
        int          n_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_listo = 0;
    int   cnt_err   = 0;

    // Pulse counters run continuously; each operation looks at the delta.
    always @(negedge clk) begin
        if (listo_pulso)  cnt_listo <= cnt_listo + 1;
        if (error_digito) cnt_err   <= cnt_err + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [3:0] sw, input int f, input int s,
                       input logic lst, input int est, input int dig, input int nl, input int ne);
        vec_t v;
        v.op = op; v.sw = sw; v.f = 12'(f); v.s = 12'(s); v.lst = lst;
        v.est = 2'(est); v.dig = 2'(dig); v.n_listo = nl; v.n_err = ne;
        vecs.push_back(v);
    endtask

    task automatic check_state(input string tag, input vec_t e);
        check({tag, ".first_num"},      int'(first_num),      int'(e.f));
        check({tag, ".second_num"},     int'(second_num),     int'(e.s));
        check({tag, ".numeros_listos"}, int'(numeros_listos), int'(e.lst));
        check({tag, ".estado"},         int'(estado),         int'(e.est));
        check({tag, ".digitos"},        int'(digitos),        int'(e.dig));
    endtask

    task automatic apply(input int idx, input vec_t v);
        int   l0, e0;
        vec_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        sb.push_back(v);
        @(negedge clk);
        l0 = cnt_listo;
        e0 = cnt_err;
        if (v.op == OP_RESET) begin
            rst = 1'b0;
            @(negedge clk);
            check({tag, ".rst_first"},  int'(first_num),  0);
            check({tag, ".rst_second"}, int'(second_num), 0);
            rst = 1'b1;
            repeat (4) @(negedge clk);
        end else begin
            sw_digit     = v.sw;
            btn_ingresar = (v.op == OP_ENTER || v.op == OP_BOTH);
            btn_borrar   = (v.op == OP_CLEAR || v.op == OP_BOTH);
            repeat (LAT + 2) @(negedge clk);
            btn_ingresar = 1'b0;
            btn_borrar   = 1'b0;
            repeat (LAT + 4) @(negedge clk);
        end
        e = sb.pop_front();
        check_state(tag, e);
        check({tag, ".listo_pulses"}, cnt_listo - l0, e.n_listo);
        check({tag, ".error_pulses"}, cnt_err - e0,   e.n_err);
    endtask

    initial begin
        rst          = 1'b0;
        sw_digit     = 4'd0;
        btn_ingresar = 1'b0;
        btn_borrar   = 1'b0;

        //   op        sw     first second lst est dig listo err
        add(OP_ENTER, 4'd1,   1,   0,   0, 0, 1, 0, 0);
        add(OP_ENTER, 4'd2,  12,   0,   0, 0, 2, 0, 0);
        add(OP_ENTER, 4'd3, 123,   0,   0, 1, 0, 0, 0);
        add(OP_ENTER, 4'd4, 123,   4,   0, 1, 1, 0, 0);
        add(OP_ENTER, 4'd5, 123,  45,   0, 1, 2, 0, 0);
        add(OP_ENTER, 4'd6, 123, 456,   1, 2, 0, 1, 0);
        add(OP_CLEAR, 4'd0,   0,   0,   0, 0, 0, 0, 0);
        add(OP_ENTER, 4'hC,   0,   0,   0, 0, 0, 0, 1);
        add(OP_ENTER, 4'd9,   9,   0,   0, 0, 1, 0, 0);
        add(OP_ENTER, 4'd9,  99,   0,   0, 0, 2, 0, 0);
        add(OP_ENTER, 4'd9, 999,   0,   0, 1, 0, 0, 0);
        add(OP_ENTER, 4'd0, 999,   0,   0, 1, 1, 0, 0);
        add(OP_ENTER, 4'd0, 999,   0,   0, 1, 2, 0, 0);
        add(OP_ENTER, 4'd0, 999,   0,   1, 2, 0, 1, 0);
        add(OP_ENTER, 4'd5, 999,   0,   1, 2, 0, 0, 0);
        add(OP_ENTER, 4'hF, 999,   0,   1, 2, 0, 0, 0);
        add(OP_CLEAR, 4'd0,   0,   0,   0, 0, 0, 0, 0);
        add(OP_ENTER, 4'd1,   1,   0,   0, 0, 1, 0, 0);
        add(OP_ENTER, 4'd2,  12,   0,   0, 0, 2, 0, 0);
        add(OP_CLEAR, 4'd0,   0,   0,   0, 0, 0, 0, 0);
        add(OP_ENTER, 4'd3,   3,   0,   0, 0, 1, 0, 0);
        add(OP_BOTH,  4'd4,   0,   0,   0, 0, 0, 0, 0);
        add(OP_BOTH,  4'hC,   0,   0,   0, 0, 0, 0, 0);
        add(OP_ENTER, 4'd3,   3,   0,   0, 0, 1, 0, 0);
        add(OP_ENTER, 4'd4,  34,   0,   0, 0, 2, 0, 0);
        add(OP_RESET, 4'd0,   0,   0,   0, 0, 0, 0, 0);
        add(OP_ENTER, 4'd0,   0,   0,   0, 0, 1, 0, 0);
        add(OP_ENTER, 4'd0,   0,   0,   0, 0, 2, 0, 0);
        add(OP_ENTER, 4'd8,   8,   0,   0, 1, 0, 0, 0);

        // Reset state while held in reset
        repeat (3) @(negedge clk);
        check("reset.first_num",  int'(first_num),      0);
        check("reset.second_num", int'(second_num),     0);
        check("reset.listos",     int'(numeros_listos), 0);
        check("reset.listo_p",    int'(listo_pulso),    0);
        check("reset.error_p",    int'(error_digito),   0);
        check("reset.estado",     int'(estado),         0);
        check("reset.digitos",    int'(digitos),        0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Bounce then hold: one digit, exactly LAT edges after the final rise.
        begin
            vec_t c;
            int   l0, e0;
            c.op = OP_CLEAR; c.sw = 4'd0; c.f = 12'd0; c.s = 12'd0; c.lst = 1'b0;
            c.est = 2'd0; c.dig = 2'd0; c.n_listo = 0; c.n_err = 0;
            apply(100, c);
            e0 = cnt_err;
            l0 = cnt_listo;
            @(negedge clk);
            sw_digit = 4'd7;
            for (int t = 0; t < 10; t++) begin
                btn_ingresar = ~btn_ingresar;
                repeat (2) @(negedge clk);
            end
            check("bounce.no_capture", int'(digitos), 0);
            btn_ingresar = 1'b1;
            repeat (LAT - 1) @(negedge clk);
            check("bounce.early_first", int'(first_num), 0);
            @(negedge clk);
            check("bounce.first_num", int'(first_num), 7);
            check("bounce.digitos",   int'(digitos),   1);
            repeat (30) @(negedge clk);
            check("bounce.held_first",  int'(first_num), 7);
            check("bounce.held_digits", int'(digitos),   1);
            btn_ingresar = 1'b0;
            repeat (LAT + 4) @(negedge clk);
            check("bounce.release_first", int'(first_num), 7);
            check("bounce.error_pulses",  cnt_err - e0,    0);
            check("bounce.listo_pulses",  cnt_listo - l0,  0);
        end

        // Switch activity with no button press changes nothing.
        for (int t = 0; t < 8; t++) begin
            sw_digit = 4'(t + 2);
            repeat (3) @(negedge clk);
        end
        check("sw_only.first_num", int'(first_num), 7);
        check("sw_only.digitos",   int'(digitos),   1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
